// File: rtl/uart_tx_frame_shifter.sv
// UART transmit frame shifter: builds start/data/parity/stop image on load and
// shifts it out LSB first, one bit per shift pulse, flagging when the frame is done.
module uart_tx_frame_shifter #(
    parameter int DATA_BITS  = 8,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load_pulse,
    input  logic                 shift_pulse,
    input  logic [DATA_BITS-1:0] data_in,
    output logic                 tx,
    output logic                 count_done,
    output logic                 busy
);

    localparam int FRAME_LEN = 1 + DATA_BITS + PARITY_EN + STOP_BITS;
    localparam int CNT_W     = $clog2(FRAME_LEN + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_LEN);

    function automatic logic parity_bit(input logic [DATA_BITS-1:0] d);
        return (^d) ^ (PARITY_ODD != 0);
    endfunction

    // Slot DATA_BITS+1 always exists because at least one stop bit follows.
    function automatic logic [FRAME_LEN-1:0] build_frame(input logic [DATA_BITS-1:0] d);
        logic [FRAME_LEN-1:0] f;
        f              = '1;
        f[0]           = 1'b0;
        f[DATA_BITS:1] = d;
        if (PARITY_EN != 0) begin
            f[DATA_BITS+1] = parity_bit(d);
        end else begin
            f[DATA_BITS+1] = 1'b1;
        end
        return f;
    endfunction

    logic [FRAME_LEN-1:0] shift_r, shift_s;
    logic [CNT_W-1:0]     bit_cnt_r, bit_cnt_s;
    logic                 count_done_r, count_done_s;
    logic                 busy_r, busy_s;

    // Next-state logic: load has priority, shifts only count while a frame is in flight.
    always_comb begin
        shift_s      = shift_r;
        bit_cnt_s    = bit_cnt_r;
        count_done_s = count_done_r;
        busy_s       = busy_r;
        if (load_pulse) begin
            shift_s      = build_frame(data_in);
            bit_cnt_s    = '0;
            count_done_s = 1'b0;
            busy_s       = 1'b1;
        end else if (shift_pulse && busy_r && !count_done_r) begin
            shift_s = {1'b1, shift_r[FRAME_LEN-1:1]};
            if (bit_cnt_r < LAST_CNT) begin
                bit_cnt_s = bit_cnt_r + 1'b1;
            end else begin
                bit_cnt_s = LAST_CNT;
            end
            if (bit_cnt_s == LAST_CNT) begin
                count_done_s = 1'b1;
                busy_s       = 1'b0;
            end else begin
                count_done_s = 1'b0;
                busy_s       = 1'b1;
            end
        end else begin
            shift_s = shift_r;
        end
    end

    // State registers with synchronous active-low reset to an idle-high line.
    always_ff @(posedge clk) begin
        if (!rst) begin
            shift_r      <= '1;
            bit_cnt_r    <= '0;
            count_done_r <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            shift_r      <= shift_s;
            bit_cnt_r    <= bit_cnt_s;
            count_done_r <= count_done_s;
            busy_r       <= busy_s;
        end
    end

    assign tx         = shift_r[0];
    assign count_done = count_done_r;
    assign busy       = busy_r;

endmodule
